// File: rtl/hex_msg_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hex_msg_if                                                       |
// | Brief   : Start/sample request and byte-stream handshake of the streamer.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface hex_msg_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] sample;
  logic              busy;
  logic              done;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    input  start,
    input  sample,
    input  tx_ready,
    output busy,
    output done,
    output tx_data,
    output tx_valid
  );

  modport slave (
    output start,
    output sample,
    output tx_ready,
    input  busy,
    input  done,
    input  tx_data,
    input  tx_valid
  );
endinterface
`default_nettype wire

// File: rtl/hex_msg_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hex_msg_streamer                                                 |
// | Brief   : Prints a captured sample as "<prefix><hex digits>[LF CR]" bytes. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module hex_msg_streamer #(
  parameter int           DATA_W     = 8,
  parameter int           PREFIX_LEN = 8,
  parameter logic [127:0] PREFIX     = "Data: 0x",
  parameter bit           HEX_UPPER  = 1'b1,
  parameter bit           EOL_EN     = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  hex_msg_if.master bus
);

  localparam int       c_DIGITS      = DATA_W / 4;
  localparam logic [3:0] c_PREFIX_LAST = (PREFIX_LEN > 0) ? 4'(PREFIX_LEN - 1) : 4'd0;
  localparam logic [3:0] c_HEX_LAST    = 4'(c_DIGITS - 1);

  generate
    if ((DATA_W % 4) != 0 || DATA_W < 4 || DATA_W > 32 || PREFIX_LEN < 0 || PREFIX_LEN > 16)
    begin : g_param_check
      $error("hex_msg_streamer: illegal DATA_W or PREFIX_LEN");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREFIX = 3'd1,
    S_HEX    = 3'd2,
    S_EOL_LF = 3'd3,
    S_EOL_CR = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_sample, w_sample_nxt;
  logic [3:0]        r_idx, w_idx_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_tx_valid, w_valid_nxt;
  logic [7:0]        r_tx_data, w_char;
  logic              w_accept;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    else if (HEX_UPPER)
      return 8'h37 + {4'h0, n};
    else
      return 8'h57 + {4'h0, n};
  endfunction

  // Character i of the prefix sits in the byte lane counted down from PREFIX_LEN-1.
  function automatic logic [7:0] prefix_char(input logic [3:0] i);
    int pos;
    pos = PREFIX_LEN - 1 - int'(i);
    if (pos < 0 || pos > 15)
      return 8'h00;
    return PREFIX[8*pos +: 8];
  endfunction

  function automatic logic [3:0] nibble_of(input logic [DATA_W-1:0] s, input logic [3:0] i);
    int pos;
    pos = c_DIGITS - 1 - int'(i);
    if (pos < 0 || pos >= c_DIGITS)
      return 4'h0;
    return s[4*pos +: 4];
  endfunction

  assign w_accept = r_tx_valid && bus.tx_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_sample_nxt = r_sample;
    w_idx_nxt    = r_idx;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_valid_nxt  = r_tx_valid;
    w_char       = 8'h00;

    case (r_state)
      S_IDLE: begin
        if (bus.start && !r_busy) begin
          w_sample_nxt = bus.sample;
          w_idx_nxt    = 4'd0;
          w_busy_nxt   = 1'b1;
          w_valid_nxt  = 1'b1;
          w_state_nxt  = (PREFIX_LEN > 0) ? S_PREFIX : S_HEX;
        end
      end
      S_PREFIX: begin
        if (w_accept) begin
          if (r_idx == c_PREFIX_LAST) begin
            w_state_nxt = S_HEX;
            w_idx_nxt   = 4'd0;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end
      S_HEX: begin
        if (w_accept) begin
          if (r_idx == c_HEX_LAST) begin
            w_idx_nxt = 4'd0;
            if (EOL_EN) begin
              w_state_nxt = S_EOL_LF;
            end else begin
              w_state_nxt = S_FIN;
              w_busy_nxt  = 1'b0;
              w_valid_nxt = 1'b0;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end
      S_EOL_LF: begin
        if (w_accept)
          w_state_nxt = S_EOL_CR;
      end
      S_EOL_CR: begin
        if (w_accept) begin
          w_state_nxt = S_FIN;
          w_busy_nxt  = 1'b0;
          w_valid_nxt = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
      end
    endcase

    // The outgoing byte is derived from the next state so it is registered on the accept edge.
    if (w_valid_nxt) begin
      case (w_state_nxt)
        S_PREFIX: w_char = prefix_char(w_idx_nxt);
        S_HEX:    w_char = hex_char(nibble_of(w_sample_nxt, w_idx_nxt));
        S_EOL_LF: w_char = 8'h0A;
        S_EOL_CR: w_char = 8'h0D;
        default:  w_char = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sample   <= '0;
      r_idx      <= 4'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_sample   <= w_sample_nxt;
      r_idx      <= w_idx_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_tx_valid <= w_valid_nxt;
      r_tx_data  <= w_char;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.tx_valid = r_tx_valid;
  assign bus.tx_data  = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_hex_msg_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_hex_msg_streamer                                              |
// | Brief   : Scoreboard bench for hex_msg_streamer in three configurations.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_hex_msg_streamer;

  logic clk;
  logic rst_n;

  hex_msg_if #(.DATA_W(8))  bus_a ();
  hex_msg_if #(.DATA_W(16)) bus_b ();
  hex_msg_if #(.DATA_W(4))  bus_c ();

  hex_msg_streamer u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  hex_msg_streamer #(.DATA_W(16), .HEX_UPPER(1'b0), .EOL_EN(1'b0))
    u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  hex_msg_streamer #(.DATA_W(4), .PREFIX_LEN(0))
    u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  int checks   = 0;
  int failures = 0;
  int done_a = 0, done_b = 0, done_c = 0;
  int exp_done_a = 0, exp_done_b = 0, exp_done_c = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] q_c[$];
  logic       stall_a = 1'b0;
  logic [7:0] stall_data_a = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input string s, input bit eol);
    logic [7:0] ch;
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      case (d)
        0: q_a.push_back(ch);
        1: q_b.push_back(ch);
        default: q_c.push_back(ch);
      endcase
    end
    if (eol) begin
      case (d)
        0: begin q_a.push_back(8'h0A); q_a.push_back(8'h0D); end
        1: begin q_b.push_back(8'h0A); q_b.push_back(8'h0D); end
        default: begin q_c.push_back(8'h0A); q_c.push_back(8'h0D); end
      endcase
    end
  endtask

  task automatic mon(input int d, input logic [7:0] act);
    logic [7:0] e;
    int sz;
    sz = (d == 0) ? q_a.size() : (d == 1) ? q_b.size() : q_c.size();
    checks++;
    if (sz == 0) begin
      failures++;
      $display("FAIL char_dut%0d unexpected: got=%02h expected=none", d, act);
    end else begin
      case (d)
        0: e = q_a.pop_front();
        1: e = q_b.pop_front();
        default: e = q_c.pop_front();
      endcase
      if (act !== e) begin
        failures++;
        $display("FAIL char_dut%0d: got=%02h expected=%02h", d, act, e);
      end
    end
  endtask

  // Monitors: consume one scoreboard entry per accepted character.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_a) begin
        checks++;
        if (!(bus_a.tx_valid && bus_a.tx_data == stall_data_a)) begin
          failures++;
          $display("FAIL hold_a: got valid=%0b data=%02h expected valid=1 data=%02h",
                   bus_a.tx_valid, bus_a.tx_data, stall_data_a);
        end
      end
      stall_a      = bus_a.tx_valid && !bus_a.tx_ready;
      stall_data_a = bus_a.tx_data;
      if (bus_a.tx_valid && bus_a.tx_ready) mon(0, bus_a.tx_data);
      if (bus_b.tx_valid && bus_b.tx_ready) mon(1, bus_b.tx_data);
      if (bus_c.tx_valid && bus_c.tx_ready) mon(2, bus_c.tx_data);
      if (bus_a.done) done_a++;
      if (bus_b.done) done_b++;
      if (bus_c.done) done_c++;
    end else begin
      stall_a = 1'b0;
    end
  end

  function automatic int qsize(input int d);
    return (d == 0) ? q_a.size() : (d == 1) ? q_b.size() : q_c.size();
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? bus_a.busy : (d == 1) ? bus_b.busy : bus_c.busy;
  endfunction

  task automatic do_start(input int d, input logic [31:0] s);
    @(posedge clk); #1;
    case (d)
      0: begin bus_a.sample = s[7:0];  bus_a.start = 1'b1; end
      1: begin bus_b.sample = s[15:0]; bus_b.start = 1'b1; end
      default: begin bus_c.sample = s[3:0]; bus_c.start = 1'b1; end
    endcase
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    bus_c.start = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (qsize(d) == 0 && !busy_of(d)) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("drain_dut%0d", d), ok, qsize(d), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    int done_before;
    logic [7:0] next_s [3];
    rst_n = 1'b0;
    bus_a.start = 1'b0; bus_a.sample = '0; bus_a.tx_ready = 1'b1;
    bus_b.start = 1'b0; bus_b.sample = '0; bus_b.tx_ready = 1'b1;
    bus_c.start = 1'b0; bus_c.sample = '0; bus_c.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", !bus_a.tx_valid && !bus_b.tx_valid && !bus_c.tx_valid, bus_a.tx_valid, 0);
    check("rst_busy",  !bus_a.busy && !bus_b.busy && !bus_c.busy, bus_a.busy, 0);
    check("rst_done",  !bus_a.done && !bus_b.done && !bus_c.done, bus_a.done, 0);
    check("rst_data",  bus_a.tx_data == 8'h00, bus_a.tx_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: default line, full-rate timing
    push(0, "Data: 0xA5", 1'b1);
    exp_done_a++;
    do_start(0, 32'hA5);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!bus_a.tx_valid || !bus_a.busy) bad++;
    end
    check("t1_valid_run", bad == 0, bad, 0);
    @(negedge clk);
    check("t1_done_cycle", bus_a.done && !bus_a.busy, {bus_a.done, bus_a.busy}, 2'b10);
    wait_idle(0);

    // 2: 16-bit lowercase, no line ending
    push(1, "Data: 0x0b3f", 1'b0);
    exp_done_b++;
    do_start(1, 32'h0B3F);
    wait_idle(1);

    // 3: random backpressure
    push(0, "Data: 0x00", 1'b1);
    exp_done_a++;
    bus_a.tx_ready = 1'b0;
    do_start(0, 32'h00);
    bad = 1;
    for (int i = 0; i < 600; i++) begin
      if (q_a.size() == 0 && !bus_a.busy) begin
        bad = 0;
        break;
      end
      @(posedge clk); #1;
      bus_a.tx_ready = ($urandom_range(0, 9) < 3);
    end
    check("t3_complete", bad == 0, q_a.size(), 0);
    bus_a.tx_ready = 1'b1;
    wait_idle(0);

    // 4: no prefix, single digit, start while busy ignored
    push(2, "F", 1'b1);
    exp_done_c++;
    do_start(2, 32'hF);
    bus_c.start = 1'b1;
    bus_c.sample = 4'h1;
    @(posedge clk); #1;
    bus_c.start = 1'b0;
    wait_idle(2);
    repeat (6) @(posedge clk);
    check("t4_done_count", done_c == exp_done_c, done_c, exp_done_c);

    // 5: reset during the 3rd prefix character
    push(0, "Da", 1'b0);
    done_before = done_a;
    do_start(0, 32'h77);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_valid_async", !bus_a.tx_valid, bus_a.tx_valid, 0);
    check("t5_busy_async", !bus_a.busy, bus_a.busy, 0);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("t5_no_done", done_a == done_before, done_a, done_before);
    check("t5_partial", q_a.size() == 0, q_a.size(), 0);
    push(0, "Data: 0x3C", 1'b1);
    exp_done_a++;
    do_start(0, 32'h3C);
    wait_idle(0);

    // 6: start held high, back-to-back lines with fresh samples
    push(0, "Data: 0x12", 1'b1);
    push(0, "Data: 0x34", 1'b1);
    push(0, "Data: 0x56", 1'b1);
    exp_done_a += 3;
    next_s[0] = 8'h56; next_s[1] = 8'h56; next_s[2] = 8'h56;
    @(posedge clk); #1;
    bus_a.sample = 8'h12;
    bus_a.start  = 1'b1;
    @(posedge clk); #1;
    bus_a.sample = 8'h34;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t6_first_char_%0d", k), bus_a.tx_valid && bus_a.busy,
            {bus_a.tx_valid, bus_a.busy}, 2'b11);
      repeat (11) @(negedge clk);
      @(negedge clk);
      check($sformatf("t6_fin_%0d", k), bus_a.done && !bus_a.tx_valid,
            {bus_a.done, bus_a.tx_valid}, 2'b10);
      if (k == 2) bus_a.start = 1'b0;
      @(negedge clk);
      check($sformatf("t6_accept_gap_%0d", k), !bus_a.busy && !bus_a.tx_valid && !bus_a.done,
            {bus_a.busy, bus_a.tx_valid, bus_a.done}, 3'b000);
      if (k < 2) begin
        @(posedge clk); #1;
        bus_a.sample = next_s[k];
      end
    end
    wait_idle(0);

    check("done_count_a", done_a == exp_done_a, done_a, exp_done_a);
    check("done_count_b", done_b == exp_done_b, done_b, exp_done_b);
    check("done_count_c", done_c == exp_done_c, done_c, exp_done_c);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
